// File: rtl/add_sum_wrbuf_if.sv
// Signal bundle between the ADD stage, GLB write port, CCU and the sum write buffer.
// master = the buffer itself, slave = its environment (ADD/GLB/CCU or a bench).
interface add_sum_wrbuf_if #(
    parameter int SRAM_WIDTH = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 3
);
    logic [ADDR_WIDTH-1:0] ADDWBF_SumWrAddr;
    logic [SRAM_WIDTH-1:0] ADDWBF_SumWrDat;
    logic                  ADDWBF_SumWrDatVld;
    logic                  WBFADD_SumWrDatRdy;
    logic [ADDR_WIDTH-1:0] WBFGLB_WrAddr;
    logic [SRAM_WIDTH-1:0] WBFGLB_WrDat;
    logic                  WBFGLB_WrDatVld;
    logic                  GLBWBF_WrDatRdy;
    logic                  CCUWBF_DrainReq;
    logic                  WBFCCU_DrainDone;
    logic                  CCUWBF_Clear;
    logic [CNT_WIDTH-1:0]  WBFCCU_Cnt;

    modport master (
        input  ADDWBF_SumWrAddr, ADDWBF_SumWrDat, ADDWBF_SumWrDatVld,
        output WBFADD_SumWrDatRdy,
        output WBFGLB_WrAddr, WBFGLB_WrDat, WBFGLB_WrDatVld,
        input  GLBWBF_WrDatRdy,
        input  CCUWBF_DrainReq, CCUWBF_Clear,
        output WBFCCU_DrainDone, WBFCCU_Cnt
    );

    modport slave (
        output ADDWBF_SumWrAddr, ADDWBF_SumWrDat, ADDWBF_SumWrDatVld,
        input  WBFADD_SumWrDatRdy,
        input  WBFGLB_WrAddr, WBFGLB_WrDat, WBFGLB_WrDatVld,
        output GLBWBF_WrDatRdy,
        output CCUWBF_DrainReq, CCUWBF_Clear,
        input  WBFCCU_DrainDone, WBFCCU_Cnt
    );
endinterface

// File: rtl/add_sum_wrbuf.sv
// Elastic FWFT write buffer between the ADD sum stream and the GLB write port,
// with a CCU drain handshake and synchronous clear.
module add_sum_wrbuf #(
    parameter int SRAM_WIDTH = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input logic            clk,
    input logic            rst_n,
    add_sum_wrbuf_if.master bus
);
    localparam int IDX_W = CNT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state, stateNext;

    logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
    logic [SRAM_WIDTH-1:0] datMem  [DEPTH];
    logic [CNT_WIDTH-1:0]  wrPtr, rdPtr, cnt, cntNext;
    logic                  full, empty, rdy, push, pop, clear;

    assign clear = bus.CCUWBF_Clear;
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[IDX_W] != rdPtr[IDX_W]) &&
                   (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]);

    // Ready comes from registered state only, so GLB back-pressure never
    // reaches the ADD pipeline combinationally.
    assign rdy  = (state == RUN) && !full && !clear;
    assign push = bus.ADDWBF_SumWrDatVld && rdy;
    assign pop  = !empty && bus.GLBWBF_WrDatRdy && !clear;

    assign bus.WBFADD_SumWrDatRdy = rdy;
    assign bus.WBFGLB_WrDatVld    = !empty;
    assign bus.WBFGLB_WrAddr      = addrMem[rdPtr[IDX_W-1:0]];
    assign bus.WBFGLB_WrDat       = datMem[rdPtr[IDX_W-1:0]];
    assign bus.WBFCCU_DrainDone   = (state == DONE);
    assign bus.WBFCCU_Cnt         = cnt;

    always_comb begin
        cntNext = cnt;
        if (clear)
            cntNext = '0;
        else if (push && !pop)
            cntNext = cnt + ONE;
        else if (pop && !push)
            cntNext = cnt - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            cnt <= cntNext;
            if (clear) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + ONE;
                if (pop)  rdPtr <= rdPtr + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addrMem[i] <= '0;
                datMem[i]  <= '0;
            end
        end else if (push) begin
            addrMem[wrPtr[IDX_W-1:0]] <= bus.ADDWBF_SumWrAddr;
            datMem[wrPtr[IDX_W-1:0]]  <= bus.ADDWBF_SumWrDat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= stateNext;
    end

    // DRAIN finishes once the buffer will be empty next cycle (clear counts too).
    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (bus.CCUWBF_DrainReq) stateNext = DRAIN;
            DRAIN:   if (cntNext == '0) stateNext = DONE;
            DONE:    stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end
endmodule

// File: tb/tb_add_sum_wrbuf.sv
// Directed self-checking bench for add_sum_wrbuf.
module tb_add_sum_wrbuf;
    localparam int SW = 256, AW = 16, CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChk = 0, nPass = 0;

    add_sum_wrbuf_if #(.SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    add_sum_wrbuf #(.SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        nChk++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [AW-1:0] a, input logic [SW-1:0] d);
        bus.ADDWBF_SumWrDatVld = vld;
        bus.ADDWBF_SumWrAddr   = a;
        bus.ADDWBF_SumWrDat    = d;
    endtask

    initial begin
        drive(1'b0, '0, '0);
        bus.GLBWBF_WrDatRdy = 1'b0;
        bus.CCUWBF_DrainReq = 1'b0;
        bus.CCUWBF_Clear    = 1'b0;

        // reset state
        tick; tick;
        chk("rst_vld",  bus.WBFGLB_WrDatVld, 0);
        chk("rst_cnt",  bus.WBFCCU_Cnt, 0);
        chk("rst_done", bus.WBFCCU_DrainDone, 0);
        chk("rst_addr", bus.WBFGLB_WrAddr, 0);
        chk("rst_dat",  bus.WBFGLB_WrDat, 0);
        rst_n = 1'b1;
        chk("rst_rdy",  bus.WBFADD_SumWrDatRdy, 1);

        // fill without pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(16'h10 + i), SW'(8'hA0 + i));
            chk("fill_rdy_pre", bus.WBFADD_SumWrDatRdy, 1);
            tick;
            chk("fill_cnt",  bus.WBFCCU_Cnt, i + 1);
            chk("fill_vld",  bus.WBFGLB_WrDatVld, 1);
            chk("fill_addr", bus.WBFGLB_WrAddr, 16'h10);
            chk("fill_dat",  bus.WBFGLB_WrDat, 8'hA0);
        end
        chk("full_rdy", bus.WBFADD_SumWrDatRdy, 0);
        drive(1'b1, 16'hEE, 8'hEE);
        tick;
        chk("full_cnt_hold", bus.WBFCCU_Cnt, 4);
        drive(1'b0, '0, '0);
        bus.GLBWBF_WrDatRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_pop_addr", bus.WBFGLB_WrAddr, 16'h10 + i);
            chk("fill_pop_dat",  bus.WBFGLB_WrDat, 8'hA0 + i);
            tick;
        end
        chk("fill_empty_vld", bus.WBFGLB_WrDatVld, 0);
        chk("fill_empty_cnt", bus.WBFCCU_Cnt, 0);

        // streaming with GLB always ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(16'h100 + i), SW'(16'hB00 + i));
            chk("strm_rdy", bus.WBFADD_SumWrDatRdy, 1);
            tick;
            chk("strm_vld",  bus.WBFGLB_WrDatVld, 1);
            chk("strm_addr", bus.WBFGLB_WrAddr, 16'h100 + i);
            chk("strm_dat",  bus.WBFGLB_WrDat, 16'hB00 + i);
            chk("strm_cnt",  bus.WBFCCU_Cnt, 1);
        end
        drive(1'b0, '0, '0);
        tick;
        chk("strm_end_cnt", bus.WBFCCU_Cnt, 0);

        // simultaneous push/pop at Cnt=2
        bus.GLBWBF_WrDatRdy = 1'b0;
        drive(1'b1, 16'h20, 8'hC0); tick;
        drive(1'b1, 16'h21, 8'hC1); tick;
        chk("pp_cnt2", bus.WBFCCU_Cnt, 2);
        drive(1'b1, 16'h22, 8'hC2);
        bus.GLBWBF_WrDatRdy = 1'b1;
        chk("pp_oldest", bus.WBFGLB_WrAddr, 16'h20);
        tick;
        chk("pp_cnt", bus.WBFCCU_Cnt, 2);
        chk("pp_next", bus.WBFGLB_WrAddr, 16'h21);
        drive(1'b0, '0, '0);
        tick;
        chk("pp_last", bus.WBFGLB_WrAddr, 16'h22);
        chk("pp_lastd", bus.WBFGLB_WrDat, 8'hC2);
        tick;
        chk("pp_empty", bus.WBFCCU_Cnt, 0);

        // back-pressure then drain
        bus.GLBWBF_WrDatRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(16'h30 + i), SW'(8'hD0 + i));
            tick;
        end
        drive(1'b0, '0, '0);
        chk("dr_cnt3", bus.WBFCCU_Cnt, 3);
        bus.CCUWBF_DrainReq = 1'b1;
        tick;
        bus.CCUWBF_DrainReq = 1'b0;
        chk("dr_rdy0", bus.WBFADD_SumWrDatRdy, 0);
        drive(1'b1, 16'h3F, 8'hDF);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("dr_stall_cnt", bus.WBFCCU_Cnt, 3);
            chk("dr_stall_done", bus.WBFCCU_DrainDone, 0);
            chk("dr_stall_addr", bus.WBFGLB_WrAddr, 16'h30);
        end
        drive(1'b0, '0, '0);
        bus.GLBWBF_WrDatRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("dr_pop_addr", bus.WBFGLB_WrAddr, 16'h30 + i);
            chk("dr_pop_done", bus.WBFCCU_DrainDone, 0);
            tick;
        end
        chk("dr_done",     bus.WBFCCU_DrainDone, 1);
        chk("dr_done_rdy", bus.WBFADD_SumWrDatRdy, 0);
        chk("dr_done_cnt", bus.WBFCCU_Cnt, 0);
        tick;
        chk("dr_after_done", bus.WBFCCU_DrainDone, 0);
        chk("dr_run_rdy",    bus.WBFADD_SumWrDatRdy, 1);

        // drain while already empty: done two cycles after request
        bus.CCUWBF_DrainReq = 1'b1;
        tick;
        bus.CCUWBF_DrainReq = 1'b0;
        chk("de_done0", bus.WBFCCU_DrainDone, 0);
        tick;
        chk("de_done1", bus.WBFCCU_DrainDone, 1);
        tick;
        chk("de_done2", bus.WBFCCU_DrainDone, 0);

        // clear with a simultaneous push
        bus.GLBWBF_WrDatRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(16'h40 + i), SW'(8'hE0 + i));
            tick;
        end
        chk("clr_cnt3", bus.WBFCCU_Cnt, 3);
        drive(1'b1, 16'h4F, 8'hEF);
        bus.CCUWBF_Clear = 1'b1;
        bus.GLBWBF_WrDatRdy = 1'b1;
        #1;
        chk("clr_rdy0", bus.WBFADD_SumWrDatRdy, 0);
        tick;
        bus.CCUWBF_Clear = 1'b0;
        drive(1'b0, '0, '0);
        chk("clr_vld", bus.WBFGLB_WrDatVld, 0);
        chk("clr_cnt", bus.WBFCCU_Cnt, 0);
        tick;
        chk("clr_nopush", bus.WBFCCU_Cnt, 0);

        // async reset mid-stream at Cnt=2
        bus.GLBWBF_WrDatRdy = 1'b0;
        drive(1'b1, 16'h50, 8'hF0); tick;
        drive(1'b1, 16'h51, 8'hF1); tick;
        drive(1'b0, '0, '0);
        chk("ar_cnt2", bus.WBFCCU_Cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",  bus.WBFGLB_WrDatVld, 0);
        chk("ar_cnt",  bus.WBFCCU_Cnt, 0);
        chk("ar_addr", bus.WBFGLB_WrAddr, 0);
        tick;
        rst_n = 1'b1;
        chk("ar_rdy", bus.WBFADD_SumWrDatRdy, 1);
        chk("ar_vld_rel", bus.WBFGLB_WrDatVld, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule

// File: doc/add_sum_wrbuf.md
Name: add_sum_wrbuf

Overview:
- Elastic write buffer directly downstream of the channel-wise ADD stage.
- Accepts the Sum write stream (address + packed data) through a valid/ready handshake and queues it in a small FIFO.
- Replays the queue to the GLB write port, so GLB write back-pressure does not stall the ADD pipeline immediately.
- Provides a CCU-driven drain handshake that guarantees all sums are committed to GLB before the next layer configuration starts.

Parameters:
- SRAM_WIDTH, 256, packed write-data width; must match the ADD stage sum width.
- ADDR_WIDTH, 16, GLB word address width.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CNT_WIDTH, 3, equals log2(DEPTH)+1; occupancy width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ADDWBF_SumWrAddr  in  ADDR_WIDTH  sum write address from ADD
- ADDWBF_SumWrDat  in  SRAM_WIDTH  sum write data from ADD
- ADDWBF_SumWrDatVld  in  1  ADD write valid
- WBFADD_SumWrDatRdy  out  1  buffer can accept
- WBFGLB_WrAddr  out  ADDR_WIDTH  GLB write address
- WBFGLB_WrDat  out  SRAM_WIDTH  GLB write data
- WBFGLB_WrDatVld  out  1  GLB write valid
- GLBWBF_WrDatRdy  in  1  GLB write ready
- CCUWBF_DrainReq  in  1  level request: stop accepting, empty the buffer
- WBFCCU_DrainDone  out  1  one-cycle pulse: buffer empty after drain
- CCUWBF_Clear  in  1  synchronous discard of all entries
- WBFCCU_Cnt  out  CNT_WIDTH  current occupancy

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - pointers 0, Cnt 0, state RUN.
  - WBFGLB_WrDatVld 0, WBFCCU_DrainDone 0.
  - WBFGLB_WrAddr/WrDat 0 (storage cleared).
  - WBFADD_SumWrDatRdy 1 in the first cycle after reset release.
- Storage: DEPTH × (ADDR_WIDTH+SRAM_WIDTH) registers.
  - Write pointer and read pointer, each log2(DEPTH)+1 bits; MSB is the wrap bit.
  - full: pointers differ only in the MSB. empty: pointers equal.
- Push: push = ADDWBF_SumWrDatVld & WBFADD_SumWrDatRdy. Writes {addr,dat} at wr_ptr; wr_ptr increments and wraps modulo 2·DEPTH.
- Pop: pop = WBFGLB_WrDatVld & GLBWBF_WrDatRdy; rd_ptr increments.
- Output is first-word-fall-through:
  - WBFGLB_WrDatVld = !empty.
  - WBFGLB_WrAddr/WrDat = entry at rd_ptr, driven combinationally from storage.
- Latency: an entry pushed in cycle N is presented with Vld=1 in cycle N+1 (buffer was empty). There is no combinational path from input to output.
- Ordering: strict FIFO; the address/data pairing is preserved.
- WBFADD_SumWrDatRdy = (state==RUN) & !full & !CCUWBF_Clear. It depends on registered state only, never on GLBWBF_WrDatRdy.
- Simultaneous push and pop:
  - Non-empty, non-full buffer: both occur and Cnt is unchanged.
  - Empty buffer: only the push occurs; no bypass.
  - Full buffer: the push is blocked, so a pop frees the slot only for the next cycle.
- Cnt: +1 on push only, −1 on pop only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- FSM states:
  - RUN: if DrainReq, go to DRAIN.
  - DRAIN: Rdy=0; pops continue. When empty, or when empty after a pop this cycle (i.e. next Cnt==0), go to DONE.
  - DONE: DrainDone=1 for exactly this cycle; Rdy=0; next state RUN.
- DrainReq is sampled only in RUN. If DrainReq is still high on return to RUN, a new drain starts; that case completes in 2 cycles with an empty buffer.
- DrainReq while already empty: RUN→DRAIN→DONE; DrainDone is asserted 2 cycles after DrainReq first goes high.
- Clear (1 cycle, any state):
  - Next cycle: pointers 0, Cnt 0, Vld 0.
  - A push or pop in the same cycle is ignored; Rdy is forced to 0 that cycle.
  - State is unaffected, except that DRAIN proceeds to DONE the next cycle.
- Reset mid-operation: all contents are lost immediately and the buffer returns to the reset values; no partial write is presented.
- Held output: while Vld=1 and Rdy=0 from GLB, WrAddr/WrDat stay stable.

Test Plan:
- Fill without pop: GLB Rdy=0; push addr 0x10..0x13 with data 0xA0..0xA3. Expected: Cnt 1,2,3,4; SumWrDatRdy=0 after 4th; Vld=1 with addr 0x10 held stable.
- Stream: GLB Rdy=1; push 8 consecutive beats with addr 0x100+i. Expected: GLB receives 0x100..0x107 in order one cycle behind; Cnt stays 1; Rdy never drops.
- Simultaneous push/pop: start at Cnt=2; push and pop in the same cycle. Expected: Cnt=2; popped entry is the oldest.
- Back-pressure then drain: Cnt=3, then assert DrainReq with GLB Rdy=0 for 5 cycles, then Rdy=1. Expected: SumWrDatRdy=0 from the DRAIN cycle; 3 pops; DrainDone pulses exactly 1 cycle after the last pop cycle; return to RUN.
- Clear: Cnt=3, pulse Clear. Expected: next cycle Vld=0 and Cnt=0; a push in the Clear cycle is not stored.
- Async reset: assert rst_n=0 mid-stream at Cnt=2. Expected: Vld=0 and Cnt=0 immediately; Rdy=1 on the first cycle after release.
